// File: rtl/anim_frame_timer.sv
// rtl/anim_frame_timer.sv - programmable animation frame timer with one-shot/auto-reload tick
//
// Counts enabled cycles up to a runtime-programmable period and emits a
// registered one-cycle tick at the end of each period. It runs either one-shot
// or auto-reload, keeps a wrapping count of completed frames and reports
// busy/done status.
//
// Optional build macro: SIM_FAST_EN
//   When defined, the effective period is (period_q >> SIM_SHIFT), floored at 1.
//   This shortens frames in simulation.
//
// Ports:
//   clock        in   system clock, rising edge
//   resetn       in   synchronous active-low reset
//   period       in   [WIDTH]    new period value in cycles
//   period_load  in   writes period into the period register
//   start        in   starts or restarts timing
//   stop         in   synchronous abort to IDLE
//   en           in   count enable; the counter holds when low
//   reload       in   1 = auto-reload, 0 = one-shot; sampled at terminal count
//   tick         out  one-cycle pulse at the end of each period
//   busy         out  high in RUN
//   done         out  high in DONE
//   count        out  [WIDTH]    current cycle count
//   frame_count  out  [FRAME_W]  periods completed since start; wraps

module anim_frame_timer #(
    parameter int               WIDTH      = 20,
    parameter int               FRAME_W    = 8,
    parameter logic [WIDTH-1:0] PERIOD_RST = 20'd833333,
    parameter int               SIM_SHIFT  = 7
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [WIDTH-1:0]   period,
    input  logic               period_load,
    input  logic               start,
    input  logic               stop,
    input  logic               en,
    input  logic               reload,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   count,
    output logic [FRAME_W-1:0] frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   period_q;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               tick_q, tick_d;
    logic [WIDTH-1:0]   p_raw;
    logic [WIDTH-1:0]   p_eff;
    logic               terminal;

`ifdef SIM_FAST_EN
    assign p_raw = period_q >> SIM_SHIFT;
`else
    assign p_raw = period_q;
`endif

    // A period of zero behaves as one, so the timer never stalls.
    assign p_eff = (p_raw == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : p_raw;

    // Only an exact match counts as terminal. If the period is lowered below
    // the current count, the counter runs on through its natural wrap, so an
    // early tick is never produced.
    assign terminal = (count_q == (p_eff - 1'b1));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            period_q <= PERIOD_RST;
        end else if (period_load) begin
            period_q <= period;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            frame_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            frame_q <= frame_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        frame_d = frame_q;
        tick_d  = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (start) begin
            state_d = ST_RUN;
            count_d = '0;
            frame_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (en) begin
                        if (terminal) begin
                            tick_d  = 1'b1;
                            count_d = '0;
                            frame_d = frame_q + 1'b1;
                            if (!reload) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    count_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign tick        = tick_q;
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign count       = count_q;
    assign frame_count = frame_q;

endmodule

// File: tb/tb_anim_frame_timer.sv
// tb/tb_anim_frame_timer.sv - directed self-checking bench for anim_frame_timer

module tb_anim_frame_timer;

    localparam int WIDTH   = 20;
    localparam int FRAME_W = 8;
    localparam logic [WIDTH-1:0] RST_P = 20'd6;
`ifdef SIM_FAST_EN
    localparam int EXP_RST_P = 1;
    localparam int EXP_1024  = 8;
`else
    localparam int EXP_RST_P = 6;
    localparam int EXP_1024  = 1024;
`endif

    logic               clock = 1'b0;
    logic               resetn = 1'b0;
    logic [WIDTH-1:0]   period = '0;
    logic               period_load = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               en = 1'b0;
    logic               reload = 1'b0;
    logic               tick;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   count;
    logic [FRAME_W-1:0] frame_count;

    int checks = 0;
    int errors = 0;

    anim_frame_timer #(
        .WIDTH(WIDTH), .FRAME_W(FRAME_W), .PERIOD_RST(RST_P), .SIM_SHIFT(7)
    ) dut (
        .clock(clock), .resetn(resetn), .period(period), .period_load(period_load),
        .start(start), .stop(stop), .en(en), .reload(reload), .tick(tick),
        .busy(busy), .done(done), .count(count), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_period(input int p);
        period = p[WIDTH-1:0];
        period_load = 1'b1;
        step();
        period_load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Measure the number of enabled edges from start until the first tick.
    task automatic measure(input string tag, input int exp_p);
        int n;
        n = 0;
        do_start();
        while (tick !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        check(tag, n, exp_p);
    endtask

    initial begin
        int ec;
        int ef;
        int et;

        #1;
        step();
        step();
        check("rst_count", count, 0);
        check("rst_frame", frame_count, 0);
        check("rst_tick", tick, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        resetn = 1'b1;

        // Auto-reload, period 4.
        load_period(4);
        reload = 1'b1;
        en = 1'b1;
        do_start();
        check("ar_count0", count, 0);
        check("ar_busy0", busy, 1);
        for (int k = 1; k <= 12; k++) begin
            step();
            check("ar_tick", tick, (k % 4 == 0) ? 1 : 0);
            check("ar_count", count, k % 4);
            check("ar_frame", frame_count, k / 4);
            check("ar_busy", busy, 1);
        end

        // One-shot, period 3.
        load_period(3);
        reload = 1'b0;
        do_start();
        step();
        step();
        check("os_tick_early", tick, 0);
        step();
        check("os_tick", tick, 1);
        check("os_done", done, 1);
        check("os_busy", busy, 0);
        check("os_frame", frame_count, 1);
        for (int k = 0; k < 10; k++) begin
            step();
            check("os_hold_tick", tick, 0);
            check("os_hold_done", done, 1);
            check("os_hold_count", count, 0);
            check("os_hold_frame", frame_count, 1);
        end
        do_start();
        check("os_restart_busy", busy, 1);
        check("os_restart_frame", frame_count, 0);

        // Period 5 with alternating enable.
        load_period(5);
        reload = 1'b1;
        en = 1'b0;
        do_start();
        ec = 0;
        ef = 0;
        for (int i = 0; i < 20; i++) begin
            en = (i % 2 == 0);
            step();
            et = 0;
            if (i % 2 == 0) begin
                if (ec == 4) begin
                    ec = 0;
                    et = 1;
                    ef++;
                end else begin
                    ec++;
                end
            end
            check("en_count", count, ec);
            check("en_tick", tick, et);
            check("en_frame", frame_count, ef);
        end
        en = 1'b1;

        // Period 0 and period 1 both tick every cycle.
        for (int p = 0; p <= 1; p++) begin
            load_period(p);
            do_start();
            for (int k = 1; k <= 4; k++) begin
                step();
                check("p01_tick", tick, 1);
                check("p01_count", count, 0);
                check("p01_frame", frame_count, k);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_frame_hold", frame_count, 4);
        check("stop_busy", busy, 0);
        check("stop_tick", tick, 0);

        // Start and stop together: stop wins.
        load_period(10);
        do_start();
        step();
        step();
        check("mid_count2", count, 2);
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        check("ss_busy", busy, 0);
        check("ss_count", count, 0);
        check("ss_tick", tick, 0);
        step();
        check("ss_idle_count", count, 0);

        // Restart with start alone.
        do_start();
        step();
        step();
        do_start();
        check("rs_count", count, 0);
        check("rs_busy", busy, 1);
        step();
        check("rs_count1", count, 1);

        // Reset mid-RUN, then confirm the period register returned to its reset value.
        step();
        resetn = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        resetn = 1'b1;
        check("mr_count", count, 0);
        check("mr_busy", busy, 0);
        check("mr_frame", frame_count, 0);
        check("mr_tick", tick, 0);
        measure("mr_period_rst", EXP_RST_P);

        // Large period: effective length depends on the build macro.
        load_period(1024);
        measure("p1024_first", EXP_1024);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/anim_frame_timer.md
Name: anim_frame_timer

Overview:
Parametrised successor to the fixed 20-bit animation frame-delay counter. Counts enabled cycles up to a runtime-programmable period and emits a one-cycle tick per period. Runs one-shot or auto-reload, keeps a running count of elapsed frames, and reports busy/done status. Sits between the animation FSM, which issues start/stop/en, and the sprite update datapath, which consumes tick.

Parameters:
WIDTH, 20, width of cycle counter and period register
FRAME_W, 8, width of elapsed-frame counter
PERIOD_RST, 20'd833333, period register value after reset (60 Hz at 50 MHz)
SIM_SHIFT, 7, right-shift applied to period when SIM_FAST_EN is defined

Ports:
clock  in  1  system clock; all logic on rising edge
resetn  in  1  synchronous, active-low reset
period  in  WIDTH  new period value in cycles
period_load  in  1  writes period into period register
start  in  1  starts or restarts timing
stop  in  1  synchronous abort to IDLE
en  in  1  count enable; counter holds when low
reload  in  1  1 = auto-reload, 0 = one-shot; sampled at terminal count
tick  out  1  registered one-cycle pulse at end of each period
busy  out  1  high in RUN
done  out  1  high in DONE (one-shot complete)
count  out  WIDTH  current cycle count
frame_count  out  FRAME_W  periods completed since start; wraps

Behaviour:
- Reset (resetn=0 at an edge): state=IDLE; count=0; frame_count=0; tick=0; period_q=PERIOD_RST. Reset has priority over every other input, including mid-RUN.
- Period register: period_load=1 writes period_q<=period in any state. A write during RUN takes effect at the next terminal-count compare.
- Effective period: P = max(period_q, 1). A period of 0 is treated as 1.
- States: IDLE, RUN, DONE. busy=(state==RUN); done=(state==DONE).
- Input priority per edge: resetn > stop > start > counting.
- stop=1: state<=IDLE, count<=0, tick<=0. frame_count holds its value.
- start=1 (any state, stop=0): state<=RUN, count<=0, frame_count<=0, tick<=0. Applies on the same edge. A start during RUN is a restart.
- RUN, en=1, count!=P-1: count<=count+1; tick<=0.
- RUN, en=1, count==P-1 (terminal count):
  - tick<=1 for exactly one cycle.
  - frame_count<=frame_count+1, wrapping at 2^FRAME_W.
  - count<=0.
  - reload=1: stay in RUN. reload=0: state<=DONE.
- RUN, en=0: count holds; tick<=0.
- DONE: count=0 and frame_count hold; tick=0; stays in DONE until start or stop.
- IDLE: count=0; tick=0; en has no effect.
- Latency:
  - start at edge E0 -> count=0 after E0.
  - With en held high: tick is high in the cycle after edge E0+P, and low after E0+P+1.
  - Auto-reload period = P enabled cycles exactly, with no gap between periods.
- P=1 with reload=1 and en=1: tick high every cycle; count stays 0.
- count is always < P, except when period_q is lowered mid-RUN to a value <= count. In that case the counter continues to 2^WIDTH-1, wraps to 0, and the terminal compare then uses the new P. No early tick is generated.

Optional Feature:
Macro SIM_FAST_EN.
- Defined: P = max(period_q >> SIM_SHIFT, 1). Shortens frames for simulation; every other rule is unchanged.
- Not defined: P = max(period_q, 1). This is the synthesis default.

Test Plan:
- Reset, then period_load with period=4, reload=1, start, en=1 held -> tick pulses every 4 cycles, first in the cycle after edge start+4; frame_count increments 1,2,3; busy=1 throughout.
- period=3, reload=0, start, en=1 -> a single tick, then done=1 and busy=0; count=0 and frame_count=1 hold for 10 more cycles; a further start returns to RUN with frame_count=0.
- period=5, en toggled 1,0,1,0,... -> tick only after 5 enabled cycles; count never advances on en=0 cycles.
- period=0, and separately period=1, with reload=1 -> tick every enabled cycle; count remains 0.
- Mid-RUN at count=2: assert start and stop together -> stop wins: IDLE, count=0, no tick. Repeat with start alone -> count restarts at 0. Repeat with resetn=0 -> all outputs at reset values and period_q=PERIOD_RST.
- With SIM_FAST_EN defined, SIM_SHIFT=7, period=1024 -> tick every 8 enabled cycles. Without the macro -> tick every 1024 enabled cycles.
